alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single combinational ALU of the RISC-V core between two requesters (port 0: execute stage, port 1: branch/address unit) using valid/ready handshakes and round-robin arbitration. The winning operands and 5-bit op_select are driven to the ALU in the grant cycle. The ALU result and zero_flag are captured into a one-entry response register tagged with the requester ID. The block sits between the requesters and the ALU instance.

## Interface
- DATA_W, 32, operand/result width (must match the ALU, 32)
- OP_W, 5, op_select width (must match the ALU, 5)
- IDLE_OP, 5'd31, op driven to the ALU when nothing is granted (ALU default case: out=0, zero_flag=0)

- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_in1, req0_in2  in  DATA_W  requester 0 operands
- req0_op  in  OP_W  requester 0 ALU op (ALU encoding 0–16)
- req1_valid, req1_ready, req1_in1, req1_in2, req1_op  same as port 0, for requester 1
- alu_in1, alu_in2  out  DATA_W  to ALU in1/in2
- alu_op  out  OP_W  to ALU op_select
- alu_out  in  DATA_W  from ALU out
- alu_zero  in  1  from ALU zero_flag
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response this cycle
- rsp_out  out  DATA_W  registered ALU result
- rsp_zero  out  1  registered zero_flag (branch/jump taken)
- rsp_id  out  1  requester that issued the response (0/1)

## Operation
- can_accept = !rsp_valid || rsp_ready. A new op is accepted only when can_accept is true, so the response register never overflows.
- Grant, combinational:
  - Only one reqN_valid is set: that port wins.
  - Both are set: the port != last_grant wins.
  - Neither is set: no grant.
- reqN_ready = can_accept && grant==N. A transfer occurs on reqN_valid && reqN_ready.
- alu_in1/alu_in2/alu_op = the granted port's fields. With no grant: 0, 0, IDLE_OP.
- Operands and op pass through unmodified. Op decode, shift amounts and signedness are the ALU's responsibility. Ops 17–31 are legal and return out=0, zero=0.
- On transfer:
  - rsp_out ← alu_out, rsp_zero ← alu_zero, rsp_id ← grant, rsp_valid ← 1.
  - last_grant ← grant.
- On rsp_valid && rsp_ready with no new transfer: rsp_valid ← 0. rsp_out/rsp_zero/rsp_id hold their values.
- Simultaneous drain and accept in the same cycle: the register is overwritten with the new result and rsp_valid stays 1. This gives full throughput.
- Response fields are stable while rsp_valid && !rsp_ready.
- Requester rules: reqN_valid must not depend on reqN_ready. Once valid is raised, fields are held until ready. The arbiter tolerates violations without corrupting its own state.
- last_grant changes only on a transfer. An idle cycle does not reset fairness.

## Timing
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_id=0.
  - last_grant=1, so port 0 wins the first contention.
  - Outputs reqN_ready=0 is not forced by reset: ready follows from can_accept=1 and the grant logic.
  - alu_* follow the combinational grant.
- Reset asserted mid-operation: a pending response is discarded. No transfer is recorded for the reset cycle.
- Latency: request accepted in cycle N → rsp_valid=1 with the result in cycle N+1.
- Throughput: one op per cycle while rsp_ready=1. Under continuous contention, ports alternate 0,1,0,1.
- Backpressure: rsp_ready=0 with rsp_valid=1 holds both reqN_ready at 0 until the drain.
- Combinational paths: reqN_valid → reqN_ready, reqN_valid → alu_*, rsp_ready → reqN_ready. There is no path from alu_out to any ready signal.

## Test plan
- Reset, then req0 only: in1=7, in2=5, op=1 (sub) → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_out=2, rsp_zero=0, rsp_id=0.
- Both valid for 4 cycles, rsp_ready=1; req0 op=0 (3+4), req1 op=10 (9==9) → grants 0,1,0,1. Responses: (7,0,id0), (0,1,id1), and so on.
- Backpressure: rsp_ready=0 after one response, with req1 valid (op=8, -1<1) → req1_ready stays 0 and rsp_* hold. When rsp_ready=1: req1 accepted that cycle; next cycle rsp_out=1, rsp_id=1.
- Jump and illegal ops: op=16 → rsp_zero=1, rsp_out=0. op=20 → rsp_out=0, rsp_zero=0. Idle cycle → alu_op=31, alu_in1=alu_in2=0.
- Assert rst_n low while rsp_valid=1 and both requests are pending → rsp_valid=0 immediately. After release, port 0 wins the first contention.
- Fairness across idle: grant port 1, two idle cycles, then both valid → port 0 granted.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two valid/ready requesters.
// The ALU result is captured into a one-entry response register tagged with the winning port.
module alu_share_arbiter #(
  parameter int                DATA_W  = 32,
  parameter int                OP_W    = 5,
  parameter logic [OP_W-1:0]   IDLE_OP = 5'd31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req0_in2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [DATA_W-1:0] req1_in2,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_zero,
  output logic              rsp_id
);
  logic              last_q, last_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              zero_q, zero_d;
  logic              id_q, id_d;
  logic              gnt_any, gnt, can_accept, xfer;
  always_comb begin
    gnt_any    = req0_valid || req1_valid;
    // Under contention the port that did not win last time goes first.
    gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    can_accept = !vld_q || rsp_ready;
    xfer       = can_accept && gnt_any;
    req0_ready = can_accept && gnt_any && !gnt;
    req1_ready = can_accept && gnt_any && gnt;
    alu_in1    = !gnt_any ? '0 : gnt ? req1_in1 : req0_in1;
    alu_in2    = !gnt_any ? '0 : gnt ? req1_in2 : req0_in2;
    alu_op     = !gnt_any ? IDLE_OP : gnt ? req1_op : req0_op;
    last_d     = xfer ? gnt : last_q;
    vld_d      = xfer || (vld_q && !rsp_ready);
    out_d      = xfer ? alu_out : out_q;
    zero_d     = xfer ? alu_zero : zero_q;
    id_d       = xfer ? gnt : id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      vld_q  <= 1'b0;
      out_q  <= '0;
      zero_q <= 1'b0;
      id_q   <= 1'b0;
    end else begin
      last_q <= last_d;
      vld_q  <= vld_d;
      out_q  <= out_d;
      zero_q <= zero_d;
      id_q   <= id_d;
    end
  end
  assign rsp_valid = vld_q;
  assign rsp_out   = out_q;
  assign rsp_zero  = zero_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed bench with a small ALU stub standing in for the core's ALU.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [4:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_id;
  logic [31:0] rsp_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_op(req1_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_zero(rsp_zero), .rsp_id(rsp_id)
  );

  // ALU stub: only the ops this bench exercises; everything else returns 0/0.
  always_comb begin
    alu_out  = 32'd0;
    alu_zero = 1'b0;
    case (alu_op)
      5'd0:  alu_out = alu_in1 + alu_in2;
      5'd1:  alu_out = alu_in1 - alu_in2;
      5'd8:  alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
      5'd10: alu_zero = (alu_in1 == alu_in2);
      5'd16: alu_zero = 1'b1;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rsp_chk(input string tag, input logic v, input logic [31:0] o, input logic z, input logic id);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, "_out"}, rsp_out, o);
    chk({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, z});
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 0; req0_in1 = 0; req0_in2 = 0; req0_op = 0;
    req1_valid = 0; req1_in1 = 0; req1_in2 = 0; req1_op = 0;
    #3;
    rsp_chk("reset", 0, 32'd0, 0, 0);
    chk("reset_alu_op", {27'd0, alu_op}, 32'd31);
    chk("reset_alu_in1", alu_in1, 32'd0);
    #10 rst_n = 1'b1;
    tick();
    // req0 alone: 7-5
    req0_valid = 1; req0_in1 = 7; req0_in2 = 5; req0_op = 1;
    #1;
    chk("sub_ready0", {31'd0, req0_ready}, 32'd1);
    chk("sub_ready1", {31'd0, req1_ready}, 32'd0);
    chk("sub_alu_op", {27'd0, alu_op}, 32'd1);
    tick();
    req0_valid = 0;
    rsp_chk("sub_rsp", 1, 32'd2, 0, 0);
    // both pending while a response is held, then async reset
    req0_valid = 1; req0_in1 = 3; req0_in2 = 4; req0_op = 0;
    req1_valid = 1; req1_in1 = 9; req1_in2 = 9; req1_op = 10;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    // continuous contention, port 0 first after reset
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready0", i), {31'd0, req0_ready}, {31'd0, i % 2 == 0});
      chk($sformatf("rr%0d_ready1", i), {31'd0, req1_ready}, {31'd0, i % 2 == 1});
      @(posedge clk);
      #1;
      if (i % 2 == 0) rsp_chk($sformatf("rr%0d", i), 1, 32'd7, 0, 0);
      else rsp_chk($sformatf("rr%0d", i), 1, 32'd0, 1, 1);
      @(negedge clk);
    end
    // backpressure with req1 slt(-1,1) pending
    req0_valid = 0; rsp_ready = 0;
    req1_in1 = 32'hFFFF_FFFF; req1_in2 = 1; req1_op = 8;
    #1;
    chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    rsp_chk("bp_hold", 1, 32'd0, 1, 1);
    chk("bp_ready1_held", {31'd0, req1_ready}, 32'd0);
    rsp_ready = 1;
    #1;
    chk("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    rsp_chk("bp_rsp", 1, 32'd1, 0, 1);
    // jump op on port 0
    req1_valid = 0;
    req0_valid = 1; req0_in1 = 0; req0_in2 = 0; req0_op = 16;
    #1;
    chk("jmp_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    rsp_chk("jmp_rsp", 1, 32'd0, 1, 0);
    // illegal op 20 on port 1
    req0_valid = 0;
    req1_valid = 1; req1_in1 = 5; req1_in2 = 6; req1_op = 20;
    #1;
    chk("ill_alu_in1", alu_in1, 32'd5);
    tick();
    rsp_chk("ill_rsp", 1, 32'd0, 0, 1);
    // idle cycle drains the response
    req1_valid = 0;
    #1;
    chk("idle_alu_op", {27'd0, alu_op}, 32'd31);
    chk("idle_alu_in1", alu_in1, 32'd0);
    chk("idle_alu_in2", alu_in2, 32'd0);
    chk("idle_ready0", {31'd0, req0_ready}, 32'd0);
    tick();
    rsp_chk("drain", 0, 32'd0, 0, 1);
    // fairness across idle: grant port 1, two idle cycles, then contention
    req1_valid = 1; req1_in1 = 1; req1_in2 = 1; req1_op = 0;
    #1;
    chk("fair_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    rsp_chk("fair_rsp", 1, 32'd2, 0, 1);
    req1_valid = 0;
    tick();
    tick();
    chk("fair_idle_valid", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1; req0_in1 = 3; req0_in2 = 4; req0_op = 0;
    req1_valid = 1; req1_in1 = 9; req1_in2 = 9; req1_op = 10;
    #1;
    chk("fair_both_ready0", {31'd0, req0_ready}, 32'd1);
    chk("fair_both_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    rsp_chk("fair_both_rsp", 1, 32'd7, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
